sar_cmp_responder: RTL and testbench
====================================

# sar_cmp_responder

Synthesizable digital stand-in for the sample-and-hold, DAC and comparator that sit on the far side of the SAR conversion controller. It captures an input code, answers each compare request by judging the controller's trial code against the held value, and shadows the binary search to flag trial-sequence errors. The block closes the conversion loop in FPGA prototypes and system simulation, and reports the expected result for cross-checking against the controller's output.

## Interface
- `WIDTH`, 8, resolution in bits of held value, trial code and result.
- `TRACK_CYCLES`, 4, cycles spent tracking `AnalogIn` before hold (legal range ≥1).
- `LFSR_SEED`, 8'hA5, non-zero seed for the dither LFSR (used only with the macro).

Ports:
- `Clock`  in  1  sole clock; all state changes on its rising edge.
- `Reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `AnalogIn`  in  WIDTH  code standing in for the analog input.
- `SampleReq`  in  1  one-cycle pulse that starts a conversion.
- `CmpReq`  in  1  one-cycle compare request from the controller.
- `SAROut`  in  WIDTH  trial code presented by the controller; valid while `CmpReq`=1.
- `Compare`  out  WIDTH=1  comparator result (1 = held ≥ trial); registered.
- `CmpAck`  out  1  one-cycle pulse marking a new `Compare` value.
- `Busy`  out  1  high in TRACK, HOLD and CONV.
- `ConvDone`  out  1  one-cycle pulse on entry to DONE.
- `Result`  out  WIDTH  shadow binary-search result; valid in DONE.
- `TrialErr`  out  1  sticky; set on any trial code mismatch.
- `Overrun`  out  1  one-cycle pulse when `SampleReq` arrives while `Busy`.

## Operation
- States: IDLE, TRACK, HOLD, CONV, DONE.
- IDLE / DONE + `SampleReq`: go to TRACK. Clear `TrialErr`, strobe counter, shadow register and `Result`.
- TRACK: `Held` <= `AnalogIn` every cycle for `TRACK_CYCLES` cycles, then go to HOLD. `Held` then freezes with the value from the last TRACK cycle.
- HOLD: one cycle, then go to CONV. The shadow register is loaded with only the MSB set.
- CONV, on `CmpReq`=1:
  - `Compare` <= (`Held`eff ≥ `SAROut`), unsigned.
  - `CmpAck` pulses.
  - If `SAROut` ≠ shadow, set `TrialErr`.
  - Shadow update: clear the current bit if the compare is 0, then set the next lower bit.
  - Strobe counter increments. Counter width is $clog2(WIDTH+1).
- After the WIDTH-th ack: go to DONE. `Result` <= final shadow (with the LSB decision applied) and `ConvDone` pulses.
- `Compare` holds its last value between acks.
- `CmpReq` outside CONV is ignored: no ack, no `Compare` change.
- `SampleReq` while `Busy` is ignored and `Overrun` pulses.
- `SampleReq` and `CmpReq` in the same cycle in DONE: the sample wins and the compare is ignored.
- Reset mid-operation (any state) forces IDLE and all reset values immediately.

## Timing
- Reset values:
  - All outputs 0 (`Compare`=0, `CmpAck`=0, `Busy`=0, `ConvDone`=0, `Result`=0, `TrialErr`=0, `Overrun`=0).
  - State IDLE; `Held`=0.
- `SampleReq` at cycle 0: `Busy`=1 from cycle 1. TRACK occupies cycles 1..`TRACK_CYCLES`, HOLD is the next cycle, and CONV follows.
- Compare latency: `CmpReq` at cycle n gives `Compare` and `CmpAck`=1 at cycle n+1.
- Back-to-back `CmpReq` on consecutive cycles is legal, one ack per request.
- `ConvDone` and `Result` become valid in the cycle after the final `CmpAck`. `Busy` drops in that same cycle.
- Minimum conversion: 1 + `TRACK_CYCLES` + 1 + WIDTH cycles to the final ack (14 at defaults).

## Configuration
- Macro: `SAR_CMP_DITHER_EN`.
- Defined: an 8-bit maximal LFSR (taps 8,6,5,4) seeded with `LFSR_SEED` advances on every `CmpReq` accepted in CONV. Its two LSBs select the dither:
  - 00 → −1
  - 01 / 10 → 0
  - 11 → +1
- `Held`eff = `Held` + dither, saturating at 0 and 2^WIDTH−1. The shadow search uses the dithered compare, so `TrialErr` stays meaningful.
- Undefined: no LFSR logic; `Held`eff = `Held` exactly.

## Test plan
- Reset: drive `Reset`=0 mid-CONV → state IDLE and all outputs 0 in the same cycle. After release, `CmpReq` gives no `CmpAck`.
- Ideal search: `AnalogIn`=8'h9C and a correct controller → 8 acks, `Compare` sequence 1,0,0,1,1,1,0,0. `Result`=8'h9C, `ConvDone` pulses once, `TrialErr`=0.
- Boundaries:
  - `AnalogIn`=8'h00 → all compares 0 except trial 8'h00 never occurs, `Result`=8'h00.
  - `AnalogIn`=8'hFF → all compares 1, `Result`=8'hFF.
- Wrong trial: 3rd `SAROut` forced to 8'hE0 instead of 8'hA0 → `TrialErr`=1 from the 3rd ack onward, cleared by the next `SampleReq`.
- Protocol misuse:
  - `SampleReq` during CONV → `Overrun` pulse, conversion unaffected.
  - `CmpReq` in IDLE → no `CmpAck`, `Compare` unchanged.
- Dither (macro defined, seed 8'hA5, `AnalogIn`=8'h80, trial 8'h80) → `Compare` follows the LFSR-predicted dither sequence. `AnalogIn`=8'hFF with +1 dither saturates and gives `Compare`=1.

Source files
------------

// File: rtl/sar_cmp_responder_if.sv
// Handshake bundle between a SAR conversion controller (master) and the
// sar_cmp_responder comparator stand-in (slave).
interface sar_cmp_responder_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] AnalogIn;
    logic             SampleReq;
    logic             CmpReq;
    logic [WIDTH-1:0] SAROut;
    logic             Compare;
    logic             CmpAck;
    logic             Busy;
    logic             ConvDone;
    logic [WIDTH-1:0] Result;
    logic             TrialErr;
    logic             Overrun;

    modport master (
        output AnalogIn, SampleReq, CmpReq, SAROut,
        input  Compare, CmpAck, Busy, ConvDone, Result, TrialErr, Overrun
    );

    modport slave (
        input  AnalogIn, SampleReq, CmpReq, SAROut,
        output Compare, CmpAck, Busy, ConvDone, Result, TrialErr, Overrun
    );
endinterface

// File: rtl/sar_cmp_responder.sv
// Sample-and-hold / DAC / comparator stand-in that shadows the SAR binary search.
// Optional compare dither via macro SAR_CMP_DITHER_EN.
module sar_cmp_responder #(
    parameter int         WIDTH        = 8,
    parameter int         TRACK_CYCLES = 4,
    parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
    input  logic                  Clock,
    input  logic                  Reset,
    sar_cmp_responder_if.slave    bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int TW = (TRACK_CYCLES > 1) ? $clog2(TRACK_CYCLES) : 1;
    localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_TRACK = 3'd1,
        S_HOLD  = 3'd2,
        S_CONV  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    if (LFSR_SEED == 8'h00) begin : g_seed_chk
        $error("LFSR_SEED must be non-zero");
    end
    if (TRACK_CYCLES < 1) begin : g_track_chk
        $error("TRACK_CYCLES must be at least 1");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] held_q, held_d;
    logic [TW-1:0]    trk_cnt_q, trk_cnt_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             compare_q, compare_d;
    logic             cmp_ack_q, cmp_ack_d;
    logic             busy_q, busy_d;
    logic             conv_done_q, conv_done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             trial_err_q, trial_err_d;
    logic             overrun_q, overrun_d;

    logic [WIDTH-1:0] held_eff_s;
    logic [WIDTH-1:0] cur_bit_s;
    logic [WIDTH-1:0] next_bit_s;
    logic             cmp_s;
    logic             busy_state_s;
    logic             cmp_accept_s;

`ifdef SAR_CMP_DITHER_EN
    logic [7:0] lfsr_q, lfsr_d;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // 00 -> -1, 11 -> +1, otherwise 0; saturates at both ends of the code range
    function automatic logic [WIDTH-1:0] dither_apply(input logic [WIDTH-1:0] h,
                                                      input logic [1:0]       sel);
        logic [WIDTH-1:0] r;
        case (sel)
            2'b00:   r = (h == {WIDTH{1'b0}}) ? h : h - {{(WIDTH-1){1'b0}}, 1'b1};
            2'b11:   r = (h == {WIDTH{1'b1}}) ? h : h + {{(WIDTH-1){1'b0}}, 1'b1};
            default: r = h;
        endcase
        return r;
    endfunction

    // Dither LFSR next value: advances only on an accepted compare
    always_comb begin
        lfsr_d = lfsr_q;
        if (cmp_accept_s) begin
            lfsr_d = lfsr_step(lfsr_q);
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // Dither LFSR register
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign held_eff_s = dither_apply(held_q, lfsr_q[1:0]);
`else
    assign held_eff_s = held_q;
`endif

    assign cmp_s        = (held_eff_s >= bus.SAROut);
    assign cur_bit_s    = MSB_ONE >> cnt_q;
    assign next_bit_s   = cur_bit_s >> 1;
    assign busy_state_s = (state_q == S_TRACK) || (state_q == S_HOLD) || (state_q == S_CONV);
    assign cmp_accept_s = (state_q == S_CONV) && (cnt_q != CW'(WIDTH)) && bus.CmpReq;

    // Next-state and next-output computation for the whole responder
    always_comb begin
        state_d     = state_q;
        held_d      = held_q;
        trk_cnt_d   = trk_cnt_q;
        cnt_d       = cnt_q;
        shadow_d    = shadow_q;
        compare_d   = compare_q;
        cmp_ack_d   = 1'b0;
        conv_done_d = 1'b0;
        result_d    = result_q;
        trial_err_d = trial_err_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.SampleReq) begin
                    state_d     = S_TRACK;
                    trk_cnt_d   = {TW{1'b0}};
                    cnt_d       = {CW{1'b0}};
                    shadow_d    = {WIDTH{1'b0}};
                    result_d    = {WIDTH{1'b0}};
                    trial_err_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            S_TRACK: begin
                held_d = bus.AnalogIn;
                if (trk_cnt_q == TW'(TRACK_CYCLES - 1)) begin
                    state_d   = S_HOLD;
                    trk_cnt_d = {TW{1'b0}};
                end else begin
                    trk_cnt_d = trk_cnt_q + TW'(1);
                end
            end
            S_HOLD: begin
                state_d  = S_CONV;
                shadow_d = MSB_ONE;
            end
            S_CONV: begin
                // One idle CONV cycle after the last ack lets ConvDone trail CmpAck
                if (cnt_q == CW'(WIDTH)) begin
                    state_d     = S_DONE;
                    result_d    = shadow_q;
                    conv_done_d = 1'b1;
                end else if (bus.CmpReq) begin
                    compare_d = cmp_s;
                    cmp_ack_d = 1'b1;
                    if (bus.SAROut != shadow_q) begin
                        trial_err_d = 1'b1;
                    end else begin
                        trial_err_d = trial_err_q;
                    end
                    shadow_d = (shadow_q & ~(cmp_s ? {WIDTH{1'b0}} : cur_bit_s)) | next_bit_s;
                    cnt_d    = cnt_q + CW'(1);
                end else begin
                    state_d = S_CONV;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (bus.SampleReq && busy_state_s) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = 1'b0;
        end

        busy_d = (state_d == S_TRACK) || (state_d == S_HOLD) || (state_d == S_CONV);
    end

    // State and registered outputs
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= S_IDLE;
            held_q      <= {WIDTH{1'b0}};
            trk_cnt_q   <= {TW{1'b0}};
            cnt_q       <= {CW{1'b0}};
            shadow_q    <= {WIDTH{1'b0}};
            compare_q   <= 1'b0;
            cmp_ack_q   <= 1'b0;
            busy_q      <= 1'b0;
            conv_done_q <= 1'b0;
            result_q    <= {WIDTH{1'b0}};
            trial_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            held_q      <= held_d;
            trk_cnt_q   <= trk_cnt_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            compare_q   <= compare_d;
            cmp_ack_q   <= cmp_ack_d;
            busy_q      <= busy_d;
            conv_done_q <= conv_done_d;
            result_q    <= result_d;
            trial_err_q <= trial_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.Compare  = compare_q;
    assign bus.CmpAck   = cmp_ack_q;
    assign bus.Busy     = busy_q;
    assign bus.ConvDone = conv_done_q;
    assign bus.Result   = result_q;
    assign bus.TrialErr = trial_err_q;
    assign bus.Overrun  = overrun_q;
endmodule

// File: tb/tb_sar_cmp_responder.sv
// Directed self-checking bench for sar_cmp_responder acting as a correct
// (or deliberately faulty) SAR controller.
module tb_sar_cmp_responder;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    sar_cmp_responder_if #(.WIDTH(8)) bus ();

    sar_cmp_responder #(
        .WIDTH(8),
        .TRACK_CYCLES(4),
        .LFSR_SEED(8'hA5)
    ) dut (
        .Clock(clk),
        .Reset(rst_n),
        .bus  (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // SampleReq (optionally with a simultaneous CmpReq), then wait until CONV
    task automatic start_conv(input logic [7:0] a, input logic also_cmp);
        bus.AnalogIn  = a;
        bus.SampleReq = 1'b1;
        bus.CmpReq    = also_cmp;
        bus.SAROut    = 8'h00;
        step();
        bus.SampleReq = 1'b0;
        bus.CmpReq    = 1'b0;
        n_cmp++;
        if ({bus.Busy, bus.CmpAck, bus.TrialErr, bus.ConvDone} !== 4'b1000 || bus.Result !== 8'h00) begin
            n_fail++;
            $display("FAIL start: busy/ack/err/done=%b result=%h, want 1000 and 00",
                     {bus.Busy, bus.CmpAck, bus.TrialErr, bus.ConvDone}, bus.Result);
        end
        repeat (5) step();
    endtask

    task automatic run_conv(input logic [7:0] a, input logic [7:0] exp_seq, input logic [7:0] exp_res,
                            input int bad_idx, input logic [7:0] bad_val, input int ovr_idx,
                            input logic also_cmp, input string name);
        logic [7:0] sh;
        logic       c;
        logic       exp_err;
        start_conv(a, also_cmp);
        sh = 8'h80;
        for (int k = 0; k < 8; k++) begin
            bus.CmpReq    = 1'b1;
            bus.SAROut    = (k == bad_idx) ? bad_val : sh;
            bus.SampleReq = (k == ovr_idx);
            step();
            c       = exp_seq[7-k];
            exp_err = (bad_idx >= 0) && (k >= bad_idx);
            n_cmp++;
            if ({bus.CmpAck, bus.Compare, bus.TrialErr, bus.Overrun, bus.Busy} !==
                {1'b1, c, exp_err, (k == ovr_idx), 1'b1}) begin
                n_fail++;
                $display("FAIL %s ack%0d: ack/cmp/err/ovr/busy=%b want %b", name, k,
                         {bus.CmpAck, bus.Compare, bus.TrialErr, bus.Overrun, bus.Busy},
                         {1'b1, c, exp_err, (k == ovr_idx), 1'b1});
            end
            if (!c) sh[7-k] = 1'b0;
            if (k < 7) sh[6-k] = 1'b1;
        end
        bus.CmpReq    = 1'b0;
        bus.SampleReq = 1'b0;
        step();
        n_cmp++;
        if ({bus.ConvDone, bus.Busy, bus.CmpAck, bus.TrialErr} !== {1'b1, 1'b0, 1'b0, (bad_idx >= 0)} ||
            bus.Result !== exp_res) begin
            n_fail++;
            $display("FAIL %s done: done/busy/ack/err=%b result=%h want %b %h", name,
                     {bus.ConvDone, bus.Busy, bus.CmpAck, bus.TrialErr}, bus.Result,
                     {1'b1, 1'b0, 1'b0, (bad_idx >= 0)}, exp_res);
        end
        step();
        n_cmp++;
        if (bus.ConvDone !== 1'b0 || bus.Result !== exp_res) begin
            n_fail++;
            $display("FAIL %s after: done=%b result=%h want 0 %h", name, bus.ConvDone, bus.Result, exp_res);
        end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({bus.Compare, bus.CmpAck, bus.Busy, bus.ConvDone, bus.TrialErr, bus.Overrun} !== 6'b0 ||
            bus.Result !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_init: outs=%b result=%h want 0",
                     {bus.Compare, bus.CmpAck, bus.Busy, bus.ConvDone, bus.TrialErr, bus.Overrun}, bus.Result);
        end
        step();
        rst_n = 1'b1;
        step();
        start_conv(8'h9C, 1'b0);
        // trials 80,C0,A0,90 on 9C give 1,0,0,1 so Compare is 1 before the reset hits
        bus.CmpReq = 1'b1; bus.SAROut = 8'h80; step();
        bus.SAROut = 8'hC0; step();
        bus.SAROut = 8'hA0; step();
        bus.SAROut = 8'h90; step();
        bus.CmpReq = 1'b0;
        n_cmp++;
        if (bus.Compare !== 1'b1 || bus.Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre: cmp=%b busy=%b want 1 1", bus.Compare, bus.Busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.Compare, bus.CmpAck, bus.Busy, bus.ConvDone, bus.TrialErr, bus.Overrun} !== 6'b0 ||
            bus.Result !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid: outs=%b result=%h want 0",
                     {bus.Compare, bus.CmpAck, bus.Busy, bus.ConvDone, bus.TrialErr, bus.Overrun}, bus.Result);
        end
        step();
        rst_n = 1'b1;
        bus.CmpReq = 1'b1;
        bus.SAROut = 8'h00;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if ({bus.CmpAck, bus.Compare, bus.Busy} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_idle_cmp%0d: ack/cmp/busy=%b want 000", i, {bus.CmpAck, bus.Compare, bus.Busy});
            end
        end
        bus.CmpReq = 1'b0;
        step();
    endtask

    task automatic test_ideal();
        run_conv(8'h9C, 8'b1001_1100, 8'h9C, -1, 8'h00, -1, 1'b0, "ideal_9C");
    endtask

    task automatic test_boundaries();
        run_conv(8'h00, 8'b0000_0000, 8'h00, -1, 8'h00, -1, 1'b0, "zero");
        run_conv(8'hFF, 8'b1111_1111, 8'hFF, -1, 8'h00, -1, 1'b0, "full");
    endtask

    task automatic test_wrong_trial();
        run_conv(8'h9C, 8'b1001_1100, 8'h9C, 2, 8'hE0, -1, 1'b0, "wrong_trial");
        // the next conversion's start_conv requires TrialErr cleared again
        run_conv(8'h9C, 8'b1001_1100, 8'h9C, -1, 8'h00, -1, 1'b0, "after_wrong");
    endtask

    task automatic test_misuse();
        run_conv(8'hFF, 8'b1111_1111, 8'hFF, -1, 8'h00, -1, 1'b0, "pre_misuse");
        // DONE with Compare=1: a request for trial 00 would still answer 1, so use
        // a held value check via ack only, then confirm Compare did not move
        bus.CmpReq = 1'b1;
        bus.SAROut = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if (bus.CmpAck !== 1'b0 || bus.Compare !== 1'b1) begin
                n_fail++;
                $display("FAIL done_cmp%0d: ack=%b cmp=%b want 0 1", i, bus.CmpAck, bus.Compare);
            end
        end
        bus.CmpReq = 1'b0;
        run_conv(8'h3A, 8'b0011_1010, 8'h3A, -1, 8'h00, -1, 1'b1, "sample_wins");
        run_conv(8'hC5, 8'b1100_0101, 8'hC5, -1, 8'h00, 3, 1'b0, "overrun");
    endtask

`ifdef SAR_CMP_DITHER_EN
    task automatic dither_conv(input logic [7:0] a, inout logic [7:0] lfsr, input string name);
        logic [7:0] eff;
        start_conv(a, 1'b0);
        for (int k = 0; k < 8; k++) begin
            bus.CmpReq = 1'b1;
            bus.SAROut = a;
            step();
            case (lfsr[1:0])
                2'b00:   eff = (a == 8'h00) ? a : a - 8'd1;
                2'b11:   eff = (a == 8'hFF) ? a : a + 8'd1;
                default: eff = a;
            endcase
            n_cmp++;
            if (bus.CmpAck !== 1'b1 || bus.Compare !== (eff >= a)) begin
                n_fail++;
                $display("FAIL %s ack%0d: ack=%b cmp=%b want 1 %b (lfsr %h)", name, k,
                         bus.CmpAck, bus.Compare, (eff >= a), lfsr);
            end
            lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
        bus.CmpReq = 1'b0;
        step();
        step();
    endtask

    task automatic test_dither();
        logic [7:0] lfsr;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        lfsr = 8'hA5;
        dither_conv(8'h80, lfsr, "dither_80");
        dither_conv(8'hFF, lfsr, "dither_FF");
    endtask
`endif

    initial begin
        bus.AnalogIn  = 8'h00;
        bus.SampleReq = 1'b0;
        bus.CmpReq    = 1'b0;
        bus.SAROut    = 8'h00;
        test_reset();
`ifdef SAR_CMP_DITHER_EN
        test_dither();
`else
        test_ideal();
        test_boundaries();
        test_wrong_trial();
        test_misuse();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
